dvp_tx_generator: RTL and testbench
===================================

Name: dvp_tx_generator

Overview:
- DVP transmitter: takes an RGB565 pixel stream and drives DVP camera-side signals (pclk, vsync, href, hsync, 8-bit data) with programmable frame timing.
- Acts as the camera-side counterpart of the DVP RX path. Used as the in-system camera emulator for loopback and self-test, and as a video output port.
- Each pixel is sent as two bytes, high byte first.

Parameters:
- DVP_DATA_W, 8, DVP data bus width.
- RGB_PXL_W, 16, input pixel width; must equal 2*DVP_DATA_W.
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.
- HBLANK, 144, blanking pclk periods per line.
- HS_W, 16, hsync pulse width in pclk periods; must be ≤ HBLANK.
- VSYNC_LINES, 3, lines with vsync high.
- VBP_LINES, 17, back-porch lines.
- VFP_LINES, 10, front-porch lines.
- PCLK_DIV, 2, clk cycles per pclk half-period; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- tx_start_i  in  1  level enable; frames run while high.
- pxl_i  in  RGB_PXL_W  RGB565 pixel.
- pxl_vld_i  in  1  pixel valid.
- pxl_rdy_o  out  1  pixel accepted when pxl_vld_i & pxl_rdy_o.
- dvp_pclk_o  out  1  generated pixel clock.
- dvp_d_o  out  DVP_DATA_W  data byte.
- dvp_href_o  out  1  line-active qualifier.
- dvp_vsync_o  out  1  frame sync, active-high.
- dvp_hsync_o  out  1  line sync, active-high.
- frame_done_o  out  1  one-clk pulse at end of each frame.
- underflow_o  out  1  sticky; set on starvation, cleared on reset or rising edge of tx_start_i.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous, active-low.
  - Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Pixel clock:
  - Divider counter; dvp_pclk_o toggles every PCLK_DIV clk cycles while not IDLE. It is held 0 in IDLE.
  - Define "fall tick" as the clk cycle in which dvp_pclk_o goes 1->0. All DVP outputs and timing counters update only on fall ticks, so data is stable across the rising edge where the receiver samples.
- Line timing: each line is 2*IMG_W + HBLANK pclk periods, counted by h_cnt.
  - ACTIVE lines: href = 1 for h_cnt < 2*IMG_W.
  - hsync = 1 for 2*IMG_W ≤ h_cnt < 2*IMG_W + HS_W, on every line in every state except IDLE.
- Frame FSM (line counter v_cnt):
  - IDLE -> VSYNC at the first fall tick after tx_start_i=1. The divider starts on tx_start_i rising.
  - VSYNC (VSYNC_LINES lines, vsync=1) -> VBP (VBP_LINES lines) -> ACTIVE (IMG_H lines) -> VFP (VFP_LINES lines).
  - At the end of VFP, frame_done_o pulses for 1 clk. Next state is VSYNC if tx_start_i=1, else IDLE.
  - A line count of zero for any porch skips that state.
- Stop semantics:
  - tx_start_i deasserting mid-frame does not truncate the frame; the current frame completes first.
  - Reset mid-frame returns everything to reset values immediately.
- Data path:
  - At the fall tick that begins an even byte slot (h_cnt even, href=1), pxl_rdy_o = 1 for exactly that clk.
  - If pxl_vld_i = 1: the pixel is latched; dvp_d_o = pxl[15:8] in this slot and pxl[7:0] in the next slot.
  - If pxl_vld_i = 0: both bytes are 0x00 and underflow_o is set. No stall occurs; timing is never stretched.
  - pxl_rdy_o is 0 at all other times, so the latency from accept to high byte on dvp_d_o is 0 clk (same edge).
  - dvp_d_o = 0 whenever href = 0.
- Simultaneous events: a rising edge of tx_start_i in the same cycle as an underflow condition clears then cannot set, because IDLE has no active slot.

Optional Feature:
- Macro: DVP_TX_TEST_PATTERN_EN.
- When defined:
  - Adds input port tp_en_i (1 bit).
  - When tp_en_i = 1, pixels come from an internal 8-bar colour generator: bar index = pixel_x*8/IMG_W, using RGB565 values white, yellow, cyan, green, magenta, red, blue, black.
  - In this mode pxl_rdy_o = 0 and underflow is never set.
- When undefined: no port and no generator logic; data comes only from the stream.

Decomposition:
- Package dvp_tx_pkg holds:
  - state encoding (IDLE, VSYNC, VBP, ACTIVE, VFP);
  - RGB565 colour-bar constants;
  - derived widths: H_TOTAL = 2*IMG_W + HBLANK, V_TOTAL, $clog2 counter widths.
- One sub-module: dvp_tx_pclk_gen (divider producing dvp_pclk_o and the fall-tick strobe).

Test Plan:
- Use IMG_W=4, IMG_H=2, HBLANK=4, HS_W=2, VSYNC/VBP/VFP=1, PCLK_DIV=1 for all scenarios.
- Reset and idle: hold rst_n=0 for 3 clk, then tx_start_i=0 for 50 clk -> every output stays 0 and pclk does not toggle.
- Single frame: pulse tx_start_i for 1 clk, stream pixels 0x1234, 0x5678, ... -> vsync high for 12 pclk; first active line has href high for 8 pclk with bytes 12,34,56,78,...; frame_done_o pulses once after 5 lines; FSM returns to IDLE.
- Underflow: pxl_vld_i=0 for the 3rd pixel -> bytes 00,00 appear in slots 4–5, underflow_o=1 and stays set until the next tx_start_i rise.
- Continuous run: tx_start_i held high -> 3 back-to-back frames, each 60 pclk, with frame_done_o spaced exactly 120 clk apart.
- Stop mid-frame: drop tx_start_i during the first active line -> the frame completes, frame_done_o pulses, then IDLE with pclk at 0.
- Reset mid-frame: assert rst_n=0 in an ACTIVE line -> all outputs 0 on the next clk; after release the next frame starts cleanly with VSYNC.

Source files
------------

// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the DVP transmitter: frame states, RGB565 colour bars
// and helpers that derive line/frame totals and counter widths.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } dvp_state_e;

  localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB565_RED     = 16'hF800;
  localparam logic [15:0] RGB565_BLUE    = 16'h001F;
  localparam logic [15:0] RGB565_BLACK   = 16'h0000;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int h_total(input int img_w, input int hblank);
    return 2 * img_w + hblank;
  endfunction

  function automatic int v_total(input int vs, input int vbp, input int img_h, input int vfp);
    return vs + vbp + img_h + vfp;
  endfunction

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB565_WHITE;
      3'd1:    return RGB565_YELLOW;
      3'd2:    return RGB565_CYAN;
      3'd3:    return RGB565_GREEN;
      3'd4:    return RGB565_MAGENTA;
      3'd5:    return RGB565_RED;
      3'd6:    return RGB565_BLUE;
      default: return RGB565_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_tx_pclk_gen.sv
// Pixel clock divider: toggles pclk every PCLK_DIV clk cycles while enabled and
// flags the cycle whose closing edge drives pclk from 1 to 0 (the fall tick).
module dvp_tx_pclk_gen
  import dvp_tx_pkg::*;
#(
  parameter int PCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pclk,
  output logic fall_tick
);

  localparam int DW = cnt_width(PCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          div_term;

  assign div_term  = (div_cnt == DIV_LAST);
  assign fall_tick = en && div_term && pclk;

  // Disabling the divider parks pclk low so a restart always begins with a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      pclk    <= 1'b0;
    end else if (div_term) begin
      div_cnt <= '0;
      pclk    <= ~pclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dvp_tx_generator.sv
// DVP camera-side transmitter: serialises RGB565 pixels as two bytes per pixel with
// programmable frame timing. Define DVP_TX_TEST_PATTERN_EN to add the colour-bar source.
module dvp_tx_generator
  import dvp_tx_pkg::*;
#(
  parameter int DVP_DATA_W  = 8,
  parameter int RGB_PXL_W   = 16,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int HBLANK      = 144,
  parameter int HS_W        = 16,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int PCLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_start_i,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic                  tp_en_i,
`endif
  input  logic [RGB_PXL_W-1:0]  pxl_i,
  input  logic                  pxl_vld_i,
  output logic                  pxl_rdy_o,
  output logic                  dvp_pclk_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  dvp_href_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_hsync_o,
  output logic                  frame_done_o,
  output logic                  underflow_o
);

  localparam int H_TOTAL = h_total(IMG_W, HBLANK);
  localparam int V_TOTAL = v_total(VSYNC_LINES, VBP_LINES, IMG_H, VFP_LINES);
  localparam int H_W     = cnt_width(H_TOTAL + 1);
  localparam int V_W     = cnt_width(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(2 * IMG_W);
  localparam logic [H_W-1:0] HS_END   = H_W'(2 * IMG_W + HS_W);
  localparam logic [V_W-1:0] VS_LAST  = V_W'((VSYNC_LINES > 0) ? VSYNC_LINES - 1 : 0);
  localparam logic [V_W-1:0] VBP_LAST = V_W'((VBP_LINES > 0) ? VBP_LINES - 1 : 0);
  localparam logic [V_W-1:0] ACT_LAST = V_W'((IMG_H > 0) ? IMG_H - 1 : 0);
  localparam logic [V_W-1:0] VFP_LAST = V_W'((VFP_LINES > 0) ? VFP_LINES - 1 : 0);

  // Zero-length porches are skipped by choosing the successor at elaboration time.
  localparam dvp_state_e FIRST_ST = (VSYNC_LINES > 0) ? ST_VSYNC :
                                    (VBP_LINES > 0)   ? ST_VBP   : ST_ACTIVE;
  localparam dvp_state_e AFTER_VS = (VBP_LINES > 0) ? ST_VBP : ST_ACTIVE;

  dvp_state_e            state, state_nxt;
  logic [H_W-1:0]        h_cnt, h_nxt;
  logic [V_W-1:0]        v_cnt, v_nxt, v_last;
  logic                  frame_end;
  logic                  start_pend;
  logic                  tx_start_q;
  logic                  pclk_en;
  logic                  fall_tick;
  logic                  href_nxt, hsync_nxt, vsync_nxt;
  logic                  slot_even, slot_odd;
  logic                  pix_ok;
  logic                  tp_sel;
  logic [RGB_PXL_W-1:0]  pix_src;
  logic [DVP_DATA_W-1:0] lo_byte;

  assign pclk_en = (state != ST_IDLE) || start_pend || tx_start_i;

  dvp_tx_pclk_gen #(
    .PCLK_DIV (PCLK_DIV)
  ) u_pclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pclk_en),
    .pclk      (dvp_pclk_o),
    .fall_tick (fall_tick)
  );

  always_comb begin
    case (state)
      ST_VSYNC:  v_last = VS_LAST;
      ST_VBP:    v_last = VBP_LAST;
      ST_ACTIVE: v_last = ACT_LAST;
      default:   v_last = VFP_LAST;
    endcase
  end

  // Position of the slot that the next fall tick will present.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    frame_end = 1'b0;
    if (state == ST_IDLE) begin
      if (tx_start_i || start_pend) begin
        state_nxt = FIRST_ST;
        h_nxt     = '0;
        v_nxt     = '0;
      end
    end else if (h_cnt != H_LAST) begin
      h_nxt = h_cnt + 1'b1;
    end else begin
      h_nxt = '0;
      if (v_cnt != v_last) begin
        v_nxt = v_cnt + 1'b1;
      end else begin
        v_nxt = '0;
        case (state)
          ST_VSYNC:  state_nxt = AFTER_VS;
          ST_VBP:    state_nxt = ST_ACTIVE;
          ST_ACTIVE: begin
            state_nxt = ST_VFP;
            frame_end = (VFP_LINES == 0);
          end
          default:   frame_end = 1'b1;
        endcase
        if (frame_end) begin
          state_nxt = tx_start_i ? FIRST_ST : ST_IDLE;
        end
      end
    end
  end

  assign href_nxt  = (state_nxt == ST_ACTIVE) && (h_nxt < H_ACT);
  assign hsync_nxt = (state_nxt != ST_IDLE) && (h_nxt >= H_ACT) && (h_nxt < HS_END);
  assign vsync_nxt = (state_nxt == ST_VSYNC);
  assign slot_even = fall_tick && href_nxt && !h_nxt[0];
  assign slot_odd  = fall_tick && href_nxt && h_nxt[0];

`ifdef DVP_TX_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'(((32'(h_nxt) >> 1) * 8) / IMG_W);
  assign tp_sel  = tp_en_i;
  assign pix_src = tp_en_i ? RGB_PXL_W'(bar_colour(bar_idx)) : pxl_i;
  assign pix_ok  = tp_en_i || pxl_vld_i;
`else
  assign tp_sel  = 1'b0;
  assign pix_src = pxl_i;
  assign pix_ok  = pxl_vld_i;
`endif

  // The handshake lands on the same edge that puts the high byte on the bus.
  assign pxl_rdy_o = rst_n && slot_even && !tp_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      start_pend <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && tx_start_i) begin
        start_pend <= 1'b1;
      end
      if (fall_tick) begin
        state <= state_nxt;
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        if (state == ST_IDLE) begin
          start_pend <= 1'b0;
        end
      end
    end
  end

  // A tx_start_i rise clears the sticky flag ahead of any same-cycle starvation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_start_q   <= 1'b0;
      frame_done_o <= 1'b0;
      underflow_o  <= 1'b0;
      dvp_vsync_o  <= 1'b0;
      dvp_hsync_o  <= 1'b0;
      dvp_href_o   <= 1'b0;
      dvp_d_o      <= '0;
      lo_byte      <= '0;
    end else begin
      tx_start_q   <= tx_start_i;
      frame_done_o <= fall_tick && frame_end;
      if (tx_start_i && !tx_start_q) begin
        underflow_o <= 1'b0;
      end else if (slot_even && !pix_ok) begin
        underflow_o <= 1'b1;
      end
      if (fall_tick) begin
        dvp_vsync_o <= vsync_nxt;
        dvp_hsync_o <= hsync_nxt;
        dvp_href_o  <= href_nxt;
        if (slot_even) begin
          dvp_d_o <= pix_ok ? pix_src[RGB_PXL_W-1 -: DVP_DATA_W] : '0;
          lo_byte <= pix_ok ? pix_src[DVP_DATA_W-1:0] : '0;
        end else if (slot_odd) begin
          dvp_d_o <= lo_byte;
        end else begin
          dvp_d_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_tx_generator.sv
// Scoreboard bench for dvp_tx_generator: a frame-level model queues the expected
// bus state for every pclk period and a monitor compares at each pclk rising edge.
module tb_dvp_tx_generator;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int HB    = 4;
  localparam int HS    = 2;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int DIV   = 1;
  localparam int HT    = 2 * W + HB;
  localparam int LINES = VS + VBP + H + VFP;
  localparam int NITEM = 512;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       hr;
    logic [7:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [15:0] pxl = '0;
  logic        pxl_vld = 1'b0;
  logic        pxl_rdy;
  logic        dvp_pclk;
  logic [7:0]  dvp_d;
  logic        dvp_href;
  logic        dvp_vsync;
  logic        dvp_hsync;
  logic        frame_done;
  logic        underflow;

  beat_t       exp_q[$];
  logic [15:0] pix_a[NITEM];
  bit          vld_a[NITEM];
  int          model_k = 0;
  int          drv_k = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          uf_exp = 1'b0;

  dvp_tx_generator #(
    .DVP_DATA_W  (8),
    .RGB_PXL_W   (16),
    .IMG_W       (W),
    .IMG_H       (H),
    .HBLANK      (HB),
    .HS_W        (HS),
    .VSYNC_LINES (VS),
    .VBP_LINES   (VBP),
    .VFP_LINES   (VFP),
    .PCLK_DIV    (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_start_i   (tx_start),
`ifdef DVP_TX_TEST_PATTERN_EN
    .tp_en_i      (1'b0),
`endif
    .pxl_i        (pxl),
    .pxl_vld_i    (pxl_vld),
    .pxl_rdy_o    (pxl_rdy),
    .dvp_pclk_o   (dvp_pclk),
    .dvp_d_o      (dvp_d),
    .dvp_href_o   (dvp_href),
    .dvp_vsync_o  (dvp_vsync),
    .dvp_hsync_o  (dvp_hsync),
    .frame_done_o (frame_done),
    .underflow_o  (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [14:0] all_out();
    return {dvp_pclk, dvp_d, dvp_href, dvp_vsync, dvp_hsync, frame_done, underflow, pxl_rdy};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // mode 0: fixed 0x1234 ramp, 1: third pixel starved, 2: random with occasional starvation
  task automatic apply_stimulus(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (model_k + i) % NITEM;
      case (mode)
        0: begin
          pix_a[idx] = 16'(16'h1234 + i * 16'h4444);
          vld_a[idx] = 1'b1;
        end
        1: begin
          pix_a[idx] = 16'($urandom);
          vld_a[idx] = (i != 2);
        end
        default: begin
          pix_a[idx] = 16'($urandom);
          vld_a[idx] = ($urandom_range(0, 7) != 0);
        end
      endcase
    end
  endtask

  task automatic push_start();
    beat_t b;
    b = '0;
    exp_q.push_back(b);
    uf_exp = 1'b0;
  endtask

  task automatic push_frame();
    for (int line = 0; line < LINES; line++) begin
      bit active;
      active = (line >= VS + VBP) && (line < VS + VBP + H);
      for (int p = 0; p < HT; p++) begin
        beat_t b;
        int    idx;
        b.vs = (line < VS);
        b.hr = active && (p < 2 * W);
        b.hs = (p >= 2 * W) && (p < 2 * W + HS);
        b.d  = 8'h00;
        if (b.hr) begin
          idx = (model_k + p / 2) % NITEM;
          if (vld_a[idx]) begin
            b.d = (p % 2 == 0) ? pix_a[idx][15:8] : pix_a[idx][7:0];
          end else begin
            uf_exp = 1'b1;
          end
        end
        exp_q.push_back(b);
      end
      if (active) model_k = (model_k + W) % NITEM;
    end
  endtask

  task automatic wait_done(input int budget, input string name, output int t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    check_output({name, "_frame_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_href(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (dvp_href) seen = 1'b1;
    end
    check_output({name, "_href_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic end_checks(input string name);
    int high_cnt;
    repeat (2) @(negedge clk);
    check_output({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check_output({name, "_underflow"}, 32'(underflow), 32'(uf_exp));
    high_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (dvp_pclk) high_cnt++;
    end
    check_output({name, "_idle_pclk"}, 32'(high_cnt), 32'd0);
  endtask

  // Pixel driver: offers the current item every cycle and advances on each acceptance.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      pxl     = pix_a[drv_k];
      pxl_vld = vld_a[drv_k];
      acc     = pxl_rdy;
      @(posedge clk);
      #1;
      if (acc) drv_k = (drv_k + 1) % NITEM;
    end
  end

  initial begin
    beat_t act, e;
    forever begin
      @(posedge dvp_pclk);
      #1;
      if (mon_en) begin
        act = {dvp_vsync, dvp_hsync, dvp_href, dvp_d};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no pclk activity (cycle %0d)", act, cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("beat", 32'(act), 32'(e));
        end
      end
    end
  end

  initial begin
    int t1, t2, t3;
    for (int i = 0; i < NITEM; i++) begin
      pix_a[i] = '0;
      vld_a[i] = 1'b0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check_output("idle_outputs", 32'(all_out()), 32'd0);
    end

    $display("[TB] single frame");
    mon_en = 1'b1;
    apply_stimulus(W * H, 0);
    push_start();
    push_frame();
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(300, "single", t1);
    end_checks("single");

    $display("[TB] underflow frame");
    apply_stimulus(W * H, 1);
    push_start();
    push_frame();
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(300, "uflow", t1);
    end_checks("uflow");

    $display("[TB] continuous run");
    apply_stimulus(3 * W * H, 2);
    push_start();
    push_frame();
    push_frame();
    push_frame();
    tx_start = 1'b1;
    @(negedge clk);
    check_output("uflow_cleared_on_start", 32'(underflow), 32'd0);
    wait_done(300, "cont1", t1);
    wait_done(300, "cont2", t2);
    tx_start = 1'b0;
    wait_done(300, "cont3", t3);
    check_output("cont_spacing_12", 32'(t2 - t1), 32'(2 * DIV * HT * LINES));
    check_output("cont_spacing_23", 32'(t3 - t2), 32'(2 * DIV * HT * LINES));
    end_checks("cont");

    $display("[TB] stop mid-frame");
    apply_stimulus(W * H, 2);
    push_start();
    push_frame();
    tx_start = 1'b1;
    wait_href(300, "stop");
    tx_start = 1'b0;
    wait_done(300, "stop", t1);
    end_checks("stop");

    $display("[TB] reset mid-frame");
    apply_stimulus(W * H, 2);
    push_start();
    push_frame();
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_href(300, "rstmid");
    mon_en = 1'b0;
    rst_n = 1'b0;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_outputs", 32'(all_out()), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_k = 0;
    drv_k = 0;
    apply_stimulus(W * H, 2);
    push_start();
    push_frame();
    mon_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(300, "rstmid", t1);
    end_checks("rstmid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
